// File: rtl/axis_arb_mux_wrr_if.sv
// AXI4-Stream bundle for the WRR mux: COUNT packed lanes on the input side, one lane on the output side.
interface axis_arb_mux_wrr_if #(
    parameter int COUNT      = 1,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [COUNT*DATA_WIDTH-1:0] tdata;
    logic [COUNT*KEEP_WIDTH-1:0] tkeep;
    logic [COUNT-1:0]            tvalid;
    logic [COUNT-1:0]            tready;
    logic [COUNT-1:0]            tlast;
    logic [COUNT*ID_WIDTH-1:0]   tid;
    logic [COUNT*DEST_WIDTH-1:0] tdest;
    logic [COUNT*USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_arb_mux_wrr.sv
// N:1 AXI4-Stream packet mux with weighted round-robin grant per packet and a
// two-register output skid so m_axis.tready never reaches s_axis.tready combinationally.
module axis_arb_mux_wrr #(
    parameter int S_COUNT      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter bit KEEP_ENABLE  = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter bit ID_ENABLE    = 0,
    parameter int S_ID_WIDTH   = 8,
    parameter int M_ID_WIDTH   = S_ID_WIDTH + $clog2(S_COUNT),
    parameter bit DEST_ENABLE  = 0,
    parameter int DEST_WIDTH   = 8,
    parameter bit USER_ENABLE  = 1,
    parameter int USER_WIDTH   = 1,
    parameter bit LAST_ENABLE  = 1,
    parameter bit UPDATE_TID   = 0,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    axis_arb_mux_wrr_if.slave                 s_axis,
    axis_arb_mux_wrr_if.master                m_axis,
    input  logic [S_COUNT*WEIGHT_WIDTH-1:0]   cfg_weight,
    output logic                              status_grant_valid,
    output logic [$clog2(S_COUNT)-1:0]        status_grant
);
    localparam int IDX_W = $clog2(S_COUNT);
    localparam int BW    = DATA_WIDTH + KEEP_WIDTH + 1 + M_ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    // state     | meaning
    // ST_IDLE   | no grant; arbitrate among requesting inputs this cycle
    // ST_ACTIVE | grant_idx_q owns the output until its packet's last beat is accepted
    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        grant_idx_q, last_idx_q, status_grant_q;
    logic [WEIGHT_WIDTH-1:0] credit_q;
    logic                    out_valid_q, temp_valid_q, int_ready_q;
    logic [BW-1:0]           out_q, temp_q;

    logic [S_COUNT-1:0]      req;
    logic                    sel_found, sel_reload;
    logic [IDX_W-1:0]        sel_idx, cand;
    logic [WEIGHT_WIDTH-1:0] sel_weight;

    always_comb begin
        req = '0;
        for (int i = 0; i < S_COUNT; i++)
            req[i] = s_axis.tvalid[i] && (cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
    end

    // Scan downward so the nearest requester after last_idx_q wins; last_idx_q itself is reached last.
    always_comb begin
        sel_found  = 1'b0;
        sel_reload = 1'b1;
        sel_idx    = last_idx_q;
        cand       = '0;
        if (credit_q != '0 && req[last_idx_q]) begin
            sel_found  = 1'b1;
            sel_reload = 1'b0;
        end else begin
            for (int k = S_COUNT; k >= 1; k--) begin
                cand = IDX_W'((int'(last_idx_q) + k) % S_COUNT);
                if (req[cand]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand;
                end
            end
        end
        sel_weight = '0;
        for (int i = 0; i < S_COUNT; i++)
            if (sel_idx == IDX_W'(i)) sel_weight = cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    logic [DATA_WIDTH-1:0] g_data;
    logic [KEEP_WIDTH-1:0] g_keep;
    logic                  g_valid, g_last;
    logic [S_ID_WIDTH-1:0] g_id;
    logic [DEST_WIDTH-1:0] g_dest;
    logic [USER_WIDTH-1:0] g_user;

    always_comb begin
        g_data  = '0;
        g_keep  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_id    = '0;
        g_dest  = '0;
        g_user  = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_idx_q == IDX_W'(i)) begin
                g_data  = s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
                g_keep  = s_axis.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                g_valid = s_axis.tvalid[i];
                g_last  = s_axis.tlast[i];
                g_id    = s_axis.tid[i*S_ID_WIDTH +: S_ID_WIDTH];
                g_dest  = s_axis.tdest[i*DEST_WIDTH +: DEST_WIDTH];
                g_user  = s_axis.tuser[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    always_comb begin
        s_axis.tready = '0;
        if (state_q == ST_ACTIVE) s_axis.tready[grant_idx_q] = int_ready_q;
    end

    logic                  accept, beat_last;
    logic [M_ID_WIDTH-1:0] int_id;
    logic [BW-1:0]         int_beat;
    logic                  int_ready_early;

    assign accept    = (state_q == ST_ACTIVE) && g_valid && int_ready_q;
    assign beat_last = LAST_ENABLE ? g_last : 1'b1;

    always_comb begin
        int_id = '0;
        if (ID_ENABLE) begin
            int_id = M_ID_WIDTH'(g_id);
            if (UPDATE_TID) int_id[M_ID_WIDTH-1 -: IDX_W] = grant_idx_q;
        end
        int_beat = {g_data,
                    KEEP_ENABLE ? g_keep : {KEEP_WIDTH{1'b1}},
                    beat_last,
                    int_id,
                    DEST_ENABLE ? g_dest : {DEST_WIDTH{1'b0}},
                    USER_ENABLE ? g_user : {USER_WIDTH{1'b0}}};
    end

    assign int_ready_early = m_axis.tready[0] || (!temp_valid_q && (!out_valid_q || !accept));

    assign m_axis.tvalid = out_valid_q;
    assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tdest, m_axis.tuser} = out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            temp_valid_q <= 1'b0;
            int_ready_q  <= 1'b0;
            out_q        <= '0;
            temp_q       <= '0;
        end else begin
            int_ready_q <= int_ready_early;
            if (int_ready_q) begin
                if (m_axis.tready[0] || !out_valid_q) begin
                    out_valid_q <= accept;
                    if (accept) out_q <= int_beat;
                end else begin
                    temp_valid_q <= accept;
                    if (accept) temp_q <= int_beat;
                end
            end else if (m_axis.tready[0]) begin
                out_valid_q  <= temp_valid_q;
                out_q        <= temp_q;
                temp_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            grant_idx_q    <= '0;
            last_idx_q     <= IDX_W'(S_COUNT - 1);
            status_grant_q <= '0;
            credit_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_found) begin
                        state_q        <= ST_ACTIVE;
                        grant_idx_q    <= sel_idx;
                        last_idx_q     <= sel_idx;
                        status_grant_q <= sel_idx;
                        if (sel_reload) credit_q <= sel_weight;
                    end
                end
                ST_ACTIVE: begin
                    if (accept && beat_last) begin
                        state_q <= ST_IDLE;
                        if (credit_q != '0) credit_q <= credit_q - WEIGHT_WIDTH'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign status_grant_valid = (state_q == ST_ACTIVE);
    assign status_grant       = status_grant_q;

endmodule
